fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory request at a time,
// redirect handling with a kill flag for in-flight responses, sticky misalignment error.
module fetch_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_base,
  input  logic [WIDTH-1:0] i_redirect_imm,
  output logic             o_mem_req,
  output logic [WIDTH-1:0] o_mem_addr,
  input  logic             i_mem_gnt,
  input  logic             i_mem_rvalid,
  input  logic [31:0]      i_mem_rdata,
  output logic             o_instr_valid,
  output logic [31:0]      o_instr,
  output logic [WIDTH-1:0] o_instr_pc,
  input  logic             i_instr_ready,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_req_pc;
  logic             r_kill;
  logic [31:0]      r_instr;
  logic [WIDTH-1:0] r_instr_pc;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_req_pc_next;
  logic             w_kill_next;
  logic             w_capture;
  logic [WIDTH-1:0] w_target;
  logic             w_misaligned;
  state_t           w_resume;

  assign w_target     = i_redirect_base + i_redirect_imm;
  assign w_misaligned = |w_target[1:0];
  assign w_resume     = i_en ? S_REQ : S_IDLE;

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_req_pc_next = r_req_pc;
    w_kill_next   = r_kill;
    w_capture     = 1'b0;
    // A misaligned redirect wins over everything and leaves pc untouched.
    if (i_redirect && (r_state != S_ERR) && w_misaligned) begin
      w_state_next = S_ERR;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_redirect) w_pc_next = w_target;
          w_state_next = w_resume;
        end
        S_REQ: begin
          if (i_redirect) begin
            w_pc_next = w_target;
            if (i_mem_gnt) begin
              w_req_pc_next = r_pc;
              w_kill_next   = 1'b1;
              w_state_next  = S_WAIT;
            end else begin
              w_state_next = w_resume;
            end
          end else if (i_mem_gnt) begin
            w_req_pc_next = r_pc;
            w_pc_next     = r_pc + WIDTH'(4);
            w_state_next  = S_WAIT;
          end else if (!i_en) begin
            w_state_next = S_IDLE;
          end
        end
        S_WAIT: begin
          if (i_redirect) begin
            w_pc_next = w_target;
            if (i_mem_rvalid) begin
              w_kill_next  = 1'b0;
              w_state_next = w_resume;
            end else begin
              w_kill_next = 1'b1;
            end
          end else if (i_mem_rvalid) begin
            w_kill_next = 1'b0;
            if (r_kill) begin
              w_state_next = w_resume;
            end else begin
              w_capture    = 1'b1;
              w_state_next = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (i_redirect) begin
            w_pc_next    = w_target;
            w_state_next = w_resume;
          end else if (i_instr_ready) begin
            w_state_next = w_resume;
          end
        end
        default: w_state_next = S_ERR;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_kill     <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_req_pc <= w_req_pc_next;
      r_kill   <= w_kill_next;
      if (w_capture) begin
        r_instr    <= i_mem_rdata;
        r_instr_pc <= r_req_pc;
      end
    end
  end

  assign o_mem_req     = (r_state == S_REQ);
  assign o_mem_addr    = o_mem_req ? r_pc : '0;
  assign o_instr_valid = (r_state == S_HOLD);
  assign o_err         = (r_state == S_ERR);
  assign o_pc          = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// each cycle checked against a transaction-level model of the fetch rules.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, redirect = 1'b0, gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
  logic [31:0] base = '0, imm = '0, rdata = '0;
  logic        mem_req, instr_valid, err;
  logic [31:0] mem_addr, instr, instr_pc, pc;

  int checks = 0;
  int errors = 0;

  // Model: pc, a requesting flag, one outstanding granted fetch, one held instruction.
  bit          m_err, m_req, m_out, m_kill, m_hold;
  logic [31:0] m_pc, m_out_pc, m_h_pc, m_h_data;

  fetch_sequencer #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_redirect(redirect),
    .i_redirect_base(base), .i_redirect_imm(imm),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_gnt(gnt),
    .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
    .o_instr_valid(instr_valid), .o_instr(instr), .o_instr_pc(instr_pc),
    .i_instr_ready(ready), .o_pc(pc), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_err = 0; m_req = 0; m_out = 0; m_kill = 0; m_hold = 0;
    m_pc = 32'h0; m_out_pc = '0; m_h_pc = '0; m_h_data = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [31:0] tgt;
    tgt = base + imm;
    if (m_err) return;
    if (redirect && (tgt[1:0] != 2'b00)) begin
      m_err = 1; m_req = 0; m_out = 0; m_hold = 0;
    end else if (redirect) begin
      if (m_req) begin
        if (gnt) begin m_out = 1; m_kill = 1; m_req = 0; end
        else m_req = en;
      end else if (m_out) begin
        if (rvalid) begin m_out = 0; m_kill = 0; m_req = en; end
        else m_kill = 1;
      end else if (m_hold) begin
        m_hold = 0; m_req = en;
      end else begin
        m_req = en;
      end
      m_pc = tgt;
    end else if (m_req) begin
      if (gnt) begin m_out = 1; m_kill = 0; m_out_pc = m_pc; m_pc = m_pc + 32'd4; m_req = 0; end
      else if (!en) m_req = 0;
    end else if (m_out) begin
      if (rvalid) begin
        m_out = 0;
        if (m_kill) begin m_kill = 0; m_req = en; end
        else begin m_hold = 1; m_h_pc = m_out_pc; m_h_data = rdata; end
      end
    end else if (m_hold) begin
      if (ready) begin m_hold = 0; m_req = en; end
    end else begin
      m_req = en;
    end
  endtask

  task automatic check_outputs();
    chk("mem_req", {31'b0, mem_req}, {31'b0, m_req});
    chk("mem_addr", mem_addr, m_req ? m_pc : 32'h0);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("pc", pc, m_pc);
    if (m_hold) begin
      chk("instr", instr, m_h_data);
      chk("instr_pc", instr_pc, m_h_pc);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_reset_zero();
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_pc", pc, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; en = 0; redirect = 0; gnt = 0; rvalid = 0; ready = 0;
    #1;
    check_reset_zero();
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int vc[3];
    logic [31:0] vpc[3];
    int nv;
    logic [31:0] r;

    model_reset();
    do_reset();

    // Back-to-back fetch with immediate grant and one-cycle response latency.
    en = 1; gnt = 1; ready = 1; rdata = 32'h00500093;
    nv = 0;
    for (int i = 0; i < 3; i++) begin vc[i] = -1; vpc[i] = 32'hDEAD_BEEF; end
    for (int c = 1; c <= 9; c++) begin
      rvalid = m_out;
      cycle();
      if (instr_valid && nv < 3) begin vc[nv] = c; vpc[nv] = instr_pc; nv++; end
    end
    chk("seq_pc0", vpc[0], 32'h0);
    chk("seq_pc1", vpc[1], 32'h4);
    chk("seq_pc2", vpc[2], 32'h8);
    chk("seq_gap01", 32'(vc[1] - vc[0]), 32'd3);
    chk("seq_gap12", 32'(vc[2] - vc[1]), 32'd3);
    chk("seq_data", instr, 32'h00500093);

    // Downstream stall in HOLD: output stable, no new request.
    rvalid = 0; ready = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("stall_instr_pc", instr_pc, 32'h8);
      chk("stall_mem_req", {31'b0, mem_req}, 32'h0);
    end
    ready = 1;
    cycle();
    chk("stall_next_addr", mem_addr, 32'hC);

    // Redirect while waiting: the in-flight response must be dropped.
    gnt = 1; cycle();
    gnt = 0; redirect = 1; base = 32'h100; imm = 32'hFFFF_FFF0; cycle();
    redirect = 0; rvalid = 1; rdata = 32'h1234_5678; cycle();
    chk("kill_valid", {31'b0, instr_valid}, 32'h0);
    chk("kill_addr", mem_addr, 32'hF0);
    rvalid = 0;

    // PC wrap-around on grant at the top of the address space.
    redirect = 1; base = 32'hFFFF_FFF0; imm = 32'hC; cycle();
    chk("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
    redirect = 0; gnt = 1; cycle();
    chk("wrap_pc", pc, 32'h0);
    gnt = 0; rvalid = 1; rdata = 32'hCAFE_0001; cycle();
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    rvalid = 0; ready = 1; cycle();
    chk("wrap_addr_zero", mem_addr, 32'h0);

    // Reset during WAIT, then a late response must be ignored.
    gnt = 1; cycle();
    gnt = 0;
    #2 rst_n = 0;
    #1 check_reset_zero();
    model_reset();
    @(negedge clk);
    rst_n = 1; en = 1; rvalid = 1; rdata = 32'hBAD0_BAD0;
    cycle();
    chk("late_rvalid_addr", mem_addr, 32'h0);
    cycle();
    chk("late_rvalid_valid", {31'b0, instr_valid}, 32'h0);
    rvalid = 0;

    // Misaligned redirect: sticky error until reset.
    redirect = 1; base = 32'h10; imm = 32'h2; cycle();
    chk("mis_err", {31'b0, err}, 32'h1);
    chk("mis_mem_req", {31'b0, mem_req}, 32'h0);
    redirect = 0; gnt = 1; rvalid = 1; ready = 1;
    for (int c = 0; c < 4; c++) cycle();
    chk("mis_err_sticky", {31'b0, err}, 32'h1);
    do_reset();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 399) do_reset();
      r = $urandom;
      en     = (r[3:0] != 4'h0);
      gnt    = r[4];
      ready  = r[5] | r[6];
      rvalid = m_out && (r[8:7] != 2'b00);
      rdata  = $urandom;
      redirect = (r[13:9] == 5'h0);
      base = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      imm  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (redirect && r[20:16] == 5'h0) imm[1:0] = 2'($urandom_range(1, 3));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
